// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding and bus constants for the block copier
package dma_pkg;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic CTRL_READ = 1'b0;
  localparam logic CTRL_WRITE = 1'b1;
  typedef enum logic [2:0] {IDLE, REQ, RD, RD_END, WR, WR_END, RELEASE} state_t;
endpackage

// File: rtl/bus_master_port.sv
// bus_master_port: tri-state bus drivers, IReady/TReady four-phase handshake and timeout counter
module bus_master_port import dma_pkg::*; #(
  parameter int AW = dma_pkg::AW,
  parameter int DW = dma_pkg::DW,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_ack,
  input  logic          req,
  input  logic          strobe,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          timeout,
  inout  wire  [DW-1:0] Data_Bus,
  inout  wire  [AW-1:0] Address_Bus,
  inout  wire           Control,
  inout  wire           IReady,
  input  logic          TReady
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] cnt;
  logic drive;
  assign drive = req && hold_ack;
  // ack is the TReady level the current phase waits for: high while strobing, low after
  assign ack = req && (strobe ? TReady : !TReady);
  assign timeout = req && !ack && cnt == LAST;
  assign rdata = Data_Bus;
  assign Address_Bus = drive ? addr : 'z;
  assign Control = drive ? (we ? CTRL_WRITE : CTRL_READ) : 1'bz;
  assign IReady = drive ? strobe : 1'bz;
  assign Data_Bus = drive && we ? wdata : 'z;
  always_ff @(posedge clk)
    if (!rst_n || !req || ack) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/dma_block_copier.sv
// dma_block_copier: burst DMA that copies a block of words from src to dst while holding the bus
module dma_block_copier import dma_pkg::*; #(
  parameter int AW = dma_pkg::AW,
  parameter int DW = dma_pkg::DW,
  parameter int CW = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          HOLD,
  input  logic          HOLD_ACK,
  inout  wire  [DW-1:0] Data_Bus,
  inout  wire  [AW-1:0] Address_Bus,
  inout  wire           Control,
  inout  wire           IReady,
  input  logic          TReady
);
  state_t st, nx;
  logic [AW-1:0] src, dst;
  logic [CW-1:0] rem;
  logic [DW-1:0] word, rdata;
  logic err_f, act, we, ack, timeout, abort;
  assign act = st inside {RD, RD_END, WR, WR_END};
  assign we = st == WR || st == WR_END;
  assign abort = act && (!HOLD_ACK || timeout);
  assign HOLD = st == REQ || act;
  assign busy = st != IDLE;
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = start && count != '0 ? REQ : IDLE;
      REQ:     nx = HOLD_ACK ? RD : REQ;
      RD:      nx = ack ? RD_END : RD;
      RD_END:  nx = ack ? WR : RD_END;
      WR:      nx = ack ? WR_END : WR;
      WR_END:  nx = ack ? (rem == CW'(1) ? RELEASE : RD) : WR_END;
      RELEASE: nx = HOLD_ACK ? RELEASE : IDLE;
      default: nx = IDLE;
    endcase
    if (abort) nx = RELEASE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      done <= 1'b0;
      error <= 1'b0;
      err_f <= 1'b0;
      src <= '0;
      dst <= '0;
      rem <= '0;
      word <= '0;
    end else begin
      st <= nx;
      done <= (st == IDLE && start && count == '0) || (st == RELEASE && !HOLD_ACK && !err_f);
      error <= st == RELEASE && !HOLD_ACK && err_f;
      if (st == IDLE && start) begin
        src <= src_addr;
        dst <= dst_addr;
        rem <= count;
        err_f <= 1'b0;
      end
      if (st == RD && ack) word <= rdata;
      if (st == WR_END && ack) begin
        src <= src + 1'b1;
        dst <= dst + 1'b1;
        rem <= rem - 1'b1;
      end
      if (abort) err_f <= 1'b1;
    end
  end
  bus_master_port #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) u_port (
    .clk,
    .rst_n,
    .hold_ack(HOLD_ACK),
    .req(act),
    .strobe(st == RD || st == WR),
    .we,
    .addr(we ? dst : src),
    .wdata(word),
    .ack,
    .rdata,
    .timeout,
    .Data_Bus,
    .Address_Bus,
    .Control,
    .IReady,
    .TReady
  );
endmodule

// File: tb/tb_dma_block_copier.sv
// tb_dma_block_copier: table-driven block copies against a zero-wait RAM slave and a HOLD/HOLD_ACK core model
module tb_dma_block_copier;
  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] cnt;
    int g;
    bit mute;
    int lat;
    int hold;
    int d;
    int e;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hack = 1'b0, mute = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, count = '0;
  logic busy, done, error, hold, tready, act;
  tri1 [31:0] dbus;
  tri1 [15:0] abus;
  tri0 ctl, ir;
  logic [31:0] ram [0:65535];
  logic [47:0] q [$];
  vec_t vt [6];
  vec_t rv;
  int checks = 0, errors = 0;
  int gdelay = 0, gcnt = 0, done_cnt = 0, err_cnt = 0, hold_cnt = 0, zviol = 0, wr_seen = 0;
  assign act = hold && hack;
  assign tready = act && ir && !mute;
  assign dbus = act && ir && !ctl ? ram[abus] : 'z;
  always #5 clk = ~clk;
  dma_block_copier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .busy(busy), .done(done), .error(error), .HOLD(hold), .HOLD_ACK(hack),
    .Data_Bus(dbus), .Address_Bus(abus), .Control(ctl), .IReady(ir), .TReady(tready)
  );
  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  // RAM slave, write scoreboard, pulse/drive monitor, then the core's grant logic
  initial begin : mon
    logic [47:0] e;
    forever begin
      @(negedge clk);
      done_cnt += done ? 1 : 0;
      err_cnt += error ? 1 : 0;
      hold_cnt += hold ? 1 : 0;
      if (!act && (abus !== 16'hFFFF || dbus !== 32'hFFFFFFFF)) zviol++;
      if (act && ir && ctl && tready) begin
        wr_seen++;
        ram[abus] = dbus;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra got=%0h exp=none", {abus, dbus});
        end else begin
          e = q.pop_front();
          chk("sb_addr", 48'(abus), 48'(e[47:32]));
          chk("sb_data", 48'(dbus), 48'(e[31:0]));
        end
      end
      if (!hold) begin
        hack = 1'b0;
        gcnt = 0;
      end else if (!hack) begin
        if (gcnt >= gdelay) hack = 1'b1;
        else gcnt++;
      end
    end
  end
  task automatic go(input vec_t v, input int k);
    int lat;
    logic [15:0] a;
    for (int i = 0; i < int'(v.cnt); i++) begin
      a = v.src + 16'(i);
      ram[a] = 32'hA0 + 32'(i) + (32'(k) << 8);
    end
    for (int i = 0; i < int'(v.cnt); i++) begin
      a = v.src + 16'(i);
      if (!v.mute) q.push_back({16'(v.dst + 16'(i)), ram[a]});
      ram[v.dst + 16'(i)] = 32'hDEADBEEF;
    end
    gdelay = v.g;
    mute = v.mute;
    done_cnt = 0;
    err_cnt = 0;
    hold_cnt = 0;
    zviol = 0;
    src_addr = v.src;
    dst_addr = v.dst;
    count = v.cnt;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!(done || error) && lat < 3000) begin
      start = lat == 4;
      if (lat == 4) begin
        src_addr = 16'h7777;
        count = 16'd1;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk($sformatf("v%0d_latency", k), 48'(lat), 48'(v.lat));
    chk($sformatf("v%0d_done", k), 48'(done_cnt), 48'(v.d));
    chk($sformatf("v%0d_error", k), 48'(err_cnt), 48'(v.e));
    chk($sformatf("v%0d_hold_cycles", k), 48'(hold_cnt), 48'(v.hold));
    chk($sformatf("v%0d_undriven", k), 48'(zviol), 48'(0));
    chk($sformatf("v%0d_sb_left", k), 48'(q.size()), 48'(0));
    chk($sformatf("v%0d_idle", k), {46'(0), hold, busy}, 48'(0));
    for (int i = 0; i < int'(v.cnt); i++)
      chk($sformatf("v%0d_ram%0d", k, i), 48'(ram[v.dst + 16'(i)]),
          v.e != 0 ? 48'h0000DEADBEEF : 48'(32'hA0 + 32'(i) + (32'(k) << 8)));
    q.delete();
  endtask
  initial begin
    int lat;
    vt[0] = '{16'h0010, 16'h0040, 16'd4, 0, 1'b0, 19, 17, 1, 0};
    vt[1] = '{16'h0100, 16'h0200, 16'd3, 12, 1'b0, 27, 25, 1, 0};
    vt[2] = '{16'h0030, 16'h0050, 16'd0, 0, 1'b0, 1, 0, 1, 0};
    vt[3] = '{16'hFFFE, 16'h0300, 16'd3, 0, 1'b0, 15, 13, 1, 0};
    vt[4] = '{16'h0020, 16'h0060, 16'd2, 0, 1'b1, 67, 65, 0, 1};
    vt[5] = '{16'h0005, 16'h0007, 16'd1, 2, 1'b0, 9, 7, 1, 0};
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {44'(0), busy, done, error, hold}, 48'(0));
    chk("reset_abus", 48'(abus), 48'h00000000FFFF);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int k = 0; k < 6; k++) go(vt[k], k);
    // reset asserted during the WR phase of word 2 of 5
    for (int i = 0; i < 5; i++) begin
      ram[16'h0400 + 16'(i)] = 32'hB0 + 32'(i);
      ram[16'h0500 + 16'(i)] = 32'hDEADBEEF;
      q.push_back({16'h0500 + 16'(i), 32'hB0 + 32'(i)});
    end
    gdelay = 0;
    mute = 1'b0;
    done_cnt = 0;
    err_cnt = 0;
    wr_seen = 0;
    src_addr = 16'h0400;
    dst_addr = 16'h0500;
    count = 16'd5;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!(wr_seen == 2 && ctl && ir) && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("rst_reach_wr2", 48'(lat < 200), 48'(1));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_hold", 48'(hold), 48'(0));
    chk("rst_busy", 48'(busy), 48'(0));
    chk("rst_abus", 48'(abus), 48'h00000000FFFF);
    chk("rst_dbus", 48'(dbus), 48'h0000FFFFFFFF);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("rst_no_pulse", 48'(done_cnt + err_cnt), 48'(0));
    chk("rst_word3_untouched", 48'(ram[16'h0502]), 48'h0000DEADBEEF);
    q.delete();
    rv = '{16'h0400, 16'h0500, 16'd5, 0, 1'b0, 23, 21, 1, 0};
    go(rv, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
